// File: rtl/router_input_buffer.sv
// Router input buffer: stores one packet from the upstream link and forwards it
// word by word to the crossbar.
module router_input_buffer #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MAX_PACKET_LEN = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  S_Req,
  output logic                  S_Ack,
  input  logic [DATA_WIDTH-1:0] S_Data,
  output logic                  Ch_S_Req,
  output logic                  Ch_M_Req,
  input  logic                  Ch_Ack,
  output logic [DATA_WIDTH-1:0] Ch_Data,
  output logic [3:0]            Des_Addr,
  output logic [7:0]            Ctr,
  output logic [7:0]            Ptr
);

  localparam int unsigned AW      = (MAX_PACKET_LEN > 1) ? $clog2(MAX_PACKET_LEN) : 1;
  localparam logic [7:0]  MAX_LEN = 8'(MAX_PACKET_LEN);

  typedef enum logic [1:0] {IDLE, RECV, SEND, DONE} state_e;

  state_e                state_q, state_d;
  logic [7:0]            ctr_q, ctr_d;
  logic [7:0]            ptr_q, ptr_d;
  logic [7:0]            wr_q, wr_d;
  logic [3:0]            des_q, des_d;
  logic                  s_ack_q, s_ack_d;
  logic                  ch_s_req_q, ch_s_req_d;
  logic                  ch_m_req_q, ch_m_req_d;
  logic [DATA_WIDTH-1:0] mem_q [MAX_PACKET_LEN];
  logic                  mem_we;
  logic [AW-1:0]         mem_waddr;
  logic                  link_xfer, ch_xfer;
  logic [7:0]            hdr_len, eff_len;

  always_comb begin
    link_xfer = S_Req && s_ack_q;
    ch_xfer   = ch_m_req_q && Ch_Ack;
    hdr_len   = S_Data[11:4];
    if (hdr_len == 8'd0)        eff_len = 8'd1;
    else if (hdr_len > MAX_LEN) eff_len = MAX_LEN;
    else                        eff_len = hdr_len;
  end

  always_comb begin
    state_d   = state_q;
    ctr_d     = ctr_q;
    ptr_d     = ptr_q;
    wr_d      = wr_q;
    des_d     = des_q;
    mem_we    = 1'b0;
    mem_waddr = '0;
    unique case (state_q)
      IDLE: begin
        if (link_xfer) begin
          mem_we  = 1'b1;
          des_d   = S_Data[3:0];
          ctr_d   = eff_len;
          wr_d    = 8'd1;
          state_d = (eff_len == 8'd1) ? SEND : RECV;
        end
      end
      RECV: begin
        // Link and channel transfers are independent and may both occur.
        if (link_xfer) begin
          mem_we    = 1'b1;
          mem_waddr = wr_q[AW-1:0];
          wr_d      = wr_q + 8'd1;
          if (wr_q + 8'd1 == ctr_q) state_d = SEND;
        end
        if (ch_xfer) ptr_d = ptr_q + 8'd1;
      end
      SEND: begin
        if (ch_xfer) begin
          ptr_d = ptr_q + 8'd1;
          if (ptr_q + 8'd1 == ctr_q) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        ctr_d   = '0;
        ptr_d   = '0;
        wr_d    = '0;
        des_d   = '0;
      end
      default: state_d = IDLE;
    endcase

    // Handshake outputs are registered, so they are derived from next-state values.
    s_ack_d    = (state_d == IDLE) || (state_d == RECV);
    ch_s_req_d = (state_d == RECV);
    ch_m_req_d = ((state_d == RECV) || (state_d == SEND)) && (ptr_d < wr_d);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= IDLE;
      ctr_q      <= '0;
      ptr_q      <= '0;
      wr_q       <= '0;
      des_q      <= '0;
      s_ack_q    <= 1'b1;
      ch_s_req_q <= 1'b0;
      ch_m_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctr_q      <= ctr_d;
      ptr_q      <= ptr_d;
      wr_q       <= wr_d;
      des_q      <= des_d;
      s_ack_q    <= s_ack_d;
      ch_s_req_q <= ch_s_req_d;
      ch_m_req_q <= ch_m_req_d;
    end
  end

  always_ff @(posedge Clock) begin
    if (mem_we) mem_q[mem_waddr] <= S_Data;
  end

  always_comb begin
    S_Ack    = s_ack_q;
    Ch_S_Req = ch_s_req_q;
    Ch_M_Req = ch_m_req_q;
    Des_Addr = des_q;
    Ctr      = ctr_q;
    Ptr      = ptr_q;
    Ch_Data  = ((state_q == RECV) || (state_q == SEND)) ? mem_q[ptr_q[AW-1:0]] : '0;
  end

endmodule
